// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults and helpers for the multi-channel clock divider
package clk_div_pkg;
  localparam int DEFAULT_DIV_1HZ = 1000000;
  localparam int DEFAULT_WIDTH = 20;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel with pending divisor, tick pulse and square wave
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEFAULT_DIV = DEFAULT_DIV_1HZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick,
  output logic             sq
);
  logic [WIDTH-1:0] cnt, div_act, div_pend, cnt_n, div_n, pend_n;
  logic wrap;
  // a write landing on a wrap or clear edge is taken straight into div_act
  always_comb begin
    pend_n = load ? load_val : div_pend;
    wrap = en && (cnt == div_act - WIDTH'(1));
    cnt_n = sync_clr ? '0 : !en ? cnt : wrap ? '0 : cnt + WIDTH'(1);
    div_n = (sync_clr || wrap) ? pend_n : div_act;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      div_act <= WIDTH'(DEFAULT_DIV);
      div_pend <= WIDTH'(DEFAULT_DIV);
      tick <= 1'b0;
      sq <= 1'b0;
    end else begin
      cnt <= cnt_n;
      div_act <= div_n;
      div_pend <= pend_n;
      tick <= wrap && !sync_clr;
      sq <= sync_clr ? 1'b0 : en ? (cnt_n >= (div_n >> 1)) : sq;
    end
  end
endmodule

// File: rtl/multi_clk_div.sv
// multi_clk_div: NUM_CH programmable dividers sharing one reference clock
module multi_clk_div
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEFAULT_DIV = DEFAULT_DIV_1HZ,
  localparam int CH_W = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wr_div,
  output logic              wr_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);
  logic valid;
  assign valid = wr_en && (wr_div != '0) && (int'(wr_ch) < NUM_CH);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_err <= 1'b0;
    else wr_err <= wr_en && !valid;
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk(clk),
      .rst(rst),
      .en(en[g]),
      .sync_clr(sync_clr),
      .load(valid && (wr_ch == CH_W'(g))),
      .load_val(wr_div),
      .tick(tick[g]),
      .sq(sq[g])
    );
  end
endmodule

// File: tb/tb_multi_clk_div.sv
// tb_multi_clk_div: directed vectors with a cycle-stamped scoreboard and a negedge monitor
module tb_multi_clk_div;
  localparam int N = 5;
  logic clk = 1'b0, rst = 1'b1, sync_clr = 1'b0, wr_en = 1'b0, wr_err;
  logic [N-1:0] en = '0, tick, sq;
  logic [2:0] wr_ch = '0;
  logic [7:0] wr_div = '0;
  int cyc = 0, n_vec = 0, n_bad = 0;
  typedef struct {
    int at;
    logic [N-1:0] tick, sq, mask;
    logic err;
    string name;
  } exp_t;
  exp_t q[$];
  exp_t e;

  multi_clk_div #(.NUM_CH(N), .WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_div(wr_div), .wr_err(wr_err), .tick(tick), .sq(sq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      n_vec++;
      if (e.at != cyc || (tick & e.mask) != (e.tick & e.mask) ||
          (sq & e.mask) != (e.sq & e.mask) || wr_err != e.err) begin
        n_bad++;
        $display("FAIL %s @%0d (due %0d): got tick=%b sq=%b err=%b, want tick=%b sq=%b err=%b mask=%b",
                 e.name, cyc, e.at, tick, sq, wr_err, e.tick, e.sq, e.err, e.mask);
      end
    end
  end

  function automatic void push(int at, logic [N-1:0] t, logic [N-1:0] s, logic [N-1:0] m,
                               logic err, string nm);
    exp_t x;
    x.at = at; x.tick = t; x.sq = s; x.mask = m; x.err = err; x.name = nm;
    q.push_back(x);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_div4(int base, string nm);
    for (int k = 1; k <= 8; k++)
      push(base + k, (k % 4 == 0) ? '1 : '0, (k % 4 >= 2) ? '1 : '0, '1, 1'b0, nm);
  endtask

  logic [N-1:0] t_w[9] = '{5'b00000, 5'b00000, 5'b11111, 5'b00000, 5'b00000,
                           5'b00010, 5'b11101, 5'b00000, 5'b00010};
  logic [N-1:0] s_w[9] = '{5'b11111, 5'b11111, 5'b00000, 5'b00010, 5'b11111,
                           5'b11101, 5'b00010, 5'b00010, 5'b11101};
  logic [N-1:0] t_e[9] = '{5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b11101,
                           5'b00000, 5'b00010, 5'b00000, 5'b11101};
  logic [N-1:0] s_e[9] = '{5'b00000, 5'b00010, 5'b11111, 5'b11101, 5'b00010,
                           5'b00010, 5'b11101, 5'b11111, 5'b00010};
  logic e_e[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [N-1:0] t_6[7] = '{5'b11111, 5'b00000, 5'b00000, 5'b00010, 5'b11100,
                           5'b00000, 5'b00011};
  logic [N-1:0] s_6[7] = '{5'b00000, 5'b00010, 5'b11110, 5'b11101, 5'b00011,
                           5'b00011, 5'b11100};

  initial begin
    int b;
    repeat (3) step();
    push(cyc, '0, '0, '1, 1'b0, "reset");
    rst = 1'b0;
    en = '1;
    push_div4(cyc, "d4_run");
    repeat (9) step();
    b = cyc;
    wr_en = 1'b1; wr_ch = 3'd1; wr_div = 8'd3;
    for (int k = 0; k < 9; k++) push(b + 1 + k, t_w[k], s_w[k], '1, 1'b0, "ch1_d3");
    step();
    wr_en = 1'b0;
    repeat (8) step();
    b = cyc;
    sync_clr = 1'b1;
    for (int k = 0; k < 9; k++) push(b + 1 + k, t_e[k], s_e[k], '1, e_e[k], "wr_err");
    step();
    sync_clr = 1'b0; wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd0;
    step();
    wr_ch = 3'd5; wr_div = 8'd7;
    step();
    wr_en = 1'b0;
    repeat (6) step();
    repeat (3) step();
    b = cyc;
    wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd6;
    for (int k = 0; k < 7; k++) push(b + 1 + k, t_6[k], s_6[k], '1, 1'b0, "wrap_wr6");
    step();
    wr_en = 1'b0;
    repeat (6) step();
    b = cyc;
    sync_clr = 1'b1;
    push(b + 1, '0, '0, '1, 1'b0, "clr_all");
    for (int k = 4; k <= 14; k++) push(b + k, '0, 5'b00100, 5'b00100, 1'b0, "en2_hold");
    push(b + 15, 5'b00100, '0, 5'b00100, 1'b0, "en2_tick");
    push(b + 16, '0, '0, 5'b00100, 1'b0, "en2_after");
    step();
    sync_clr = 1'b0;
    repeat (2) step();
    en = 5'b11011;
    repeat (10) step();
    en = '1;
    repeat (3) step();
    wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd4;
    step();
    wr_ch = 3'd1; sync_clr = 1'b1;
    step();
    wr_en = 1'b0; sync_clr = 1'b0;
    b = cyc;
    push(b, '0, '0, '1, 1'b0, "clr_wr");
    push_div4(b, "aligned");
    repeat (9) step();
    wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd6;
    step();
    wr_en = 1'b0;
    push(cyc + 2, '0, '0, '1, 1'b0, "async_rst");
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    push_div4(cyc, "post_rst");
    repeat (11) step();
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
